adc_result_reader: RTL



---
 rtl/adc_result_reader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/adc_result_reader.sv
// SPI master that reads one 168-bit conversion record from the converter and presents it as parallel registers.
// Optional build macro ADC_READER_RESIDUE_EN adds the signed combined residue output.
module adc_result_reader #(
    parameter int          CLKDIV = 4,
    parameter logic [7:0]  CMD    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        sck,
    output logic        cs,
    output logic        mosi,
    input  logic        miso,
    output logic [31:0] pwm_na,
    output logic [31:0] pwm_nb,
    output logic [31:0] pwm_pa,
    output logic [31:0] pwm_pb,
    output logic [11:0] rundown,
    output logic [7:0]  n64,
    output logic [7:0]  p8,
    output logic [7:0]  n1,
    output logic        frame_err
`ifdef ADC_READER_RESIDUE_EN
    ,
    output logic [22:0] residue
`endif
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] HALF_LAST = 8'(CLKDIV - 1);
    localparam logic [7:0] BIT_LAST  = 8'd175;
    localparam logic [7:0] CMD_BITS  = 8'd8;

    state_t       state;
    logic [7:0]   halfCnt;
    logic [7:0]   bitCnt;
    logic [7:0]   cmdSr;
    logic [167:0] dataSr;
    logic         halfEnd;

    assign halfEnd = (halfCnt == HALF_LAST);

`ifdef ADC_READER_RESIDUE_EN
    // rundown*512 - n64*64 + p8*8 - n1, operands zero-extended into 23 bits
    logic [22:0] residueNext;
    always_comb begin
        residueNext = {2'b0, dataSr[35:24], 9'b0}
                    - {9'b0, dataSr[23:16], 6'b0}
                    + {12'b0, dataSr[15:8], 3'b0}
                    - {15'b0, dataSr[7:0]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            halfCnt   <= 8'd0;
            bitCnt    <= 8'd0;
            cmdSr     <= 8'd0;
            dataSr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sck       <= 1'b0;
            cs        <= 1'b1;
            mosi      <= 1'b0;
            pwm_na    <= 32'd0;
            pwm_nb    <= 32'd0;
            pwm_pa    <= 32'd0;
            pwm_pb    <= 32'd0;
            rundown   <= 12'd0;
            n64       <= 8'd0;
            p8        <= 8'd0;
            n1        <= 8'd0;
            frame_err <= 1'b0;
`ifdef ADC_READER_RESIDUE_EN
            residue   <= 23'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SETUP;
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        mosi    <= CMD[7];
                        cmdSr   <= {CMD[6:0], 1'b0};
                        halfCnt <= 8'd0;
                    end
                end
                SETUP: begin
                    if (halfEnd) begin
                        state   <= SHIFT;
                        halfCnt <= 8'd0;
                        bitCnt  <= 8'd0;
                    end else begin
                        halfCnt <= halfCnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (!halfEnd) begin
                        halfCnt <= halfCnt + 8'd1;
                    end else begin
                        halfCnt <= 8'd0;
                        if (!sck) begin
                            // rising transition: capture data bits, the command period is discarded
                            sck <= 1'b1;
                            if (bitCnt >= CMD_BITS) begin
                                dataSr <= {dataSr[166:0], miso};
                            end
                        end else begin
                            sck <= 1'b0;
                            if (bitCnt == BIT_LAST) begin
                                state <= HOLD;
                                mosi  <= 1'b0;
                            end else begin
                                bitCnt <= bitCnt + 8'd1;
                                mosi   <= cmdSr[7];
                                cmdSr  <= {cmdSr[6:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (halfEnd) begin
                        state     <= GAP;
                        halfCnt   <= 8'd0;
                        cs        <= 1'b1;
                        done      <= 1'b1;
                        pwm_na    <= dataSr[167:136];
                        pwm_nb    <= dataSr[135:104];
                        pwm_pa    <= dataSr[103:72];
                        pwm_pb    <= dataSr[71:40];
                        frame_err <= (dataSr[39:36] != 4'd0);
                        rundown   <= dataSr[35:24];
                        n64       <= dataSr[23:16];
                        p8        <= dataSr[15:8];
                        n1        <= dataSr[7:0];
`ifdef ADC_READER_RESIDUE_EN
                        residue   <= residueNext;
`endif
                    end else begin
                        halfCnt <= halfCnt + 8'd1;
                    end
                end
                GAP: begin
                    if (halfEnd) begin
                        state   <= IDLE;
                        halfCnt <= 8'd0;
                        busy    <= 1'b0;
                    end else begin
                        halfCnt <= halfCnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
